axi_lite_master_param: RTL and testbench
========================================

Name: axi_lite_master_param

Overview:
- Parametrised AXI4-Lite master that bridges the internal single-request interface (transfer/ready) to all five AXI-Lite channels.
- Supports full write and read transactions with independent AW and W handshakes and byte strobes.
- Captures response codes and guards the response phase with a timeout.
- Sits between CPU-side or test-sequencer logic and AXI-Lite slave peripherals.

Parameters:
- ADDR_W, 32, AXI address width (AWADDR/ARADDR/addr).
- DATA_W, 32, data width; must be 32 or 64.
- TIMEOUT, 256, max cycles waiting in a response state before abort; 0 disables the timeout.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- AWADDR  out  ADDR_W  write address.
- AWVALID  out  1  write address valid.
- AWREADY  in  1  write address ready.
- WDATA  out  DATA_W  write data.
- WSTRB  out  DATA_W/8  write byte strobes.
- WVALID  out  1  write data valid.
- WREADY  in  1  write data ready.
- BRESP  in  2  write response.
- BVALID  in  1  write response valid.
- BREADY  out  1  write response ready.
- ARADDR  out  ADDR_W  read address.
- ARVALID  out  1  read address valid.
- ARREADY  in  1  read address ready.
- RDATA  in  DATA_W  read data.
- RRESP  in  2  read response.
- RVALID  in  1  read data valid.
- RREADY  out  1  read data ready.
- transfer  in  1  request strobe; sampled only in IDLE.
- write  in  1  1 = write, 0 = read; sampled with transfer.
- addr  in  ADDR_W  request address.
- wdata  in  DATA_W  request write data.
- wstrb  in  DATA_W/8  request byte strobes.
- busy  out  1  high in every state except IDLE.
- ready  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  captured read data; holds until the next read completes.
- resp  out  2  captured BRESP/RRESP, or 2'b10 on timeout.
- timeout_err  out  1  high with ready when the transaction was aborted by timeout.

Behaviour:
- Reset (ARESETn=0 at an ACLK edge): state=IDLE.
  - All VALID/READY outputs, ready, busy, timeout_err = 0.
  - rdata = 0, resp = 2'b00.
  - Reset mid-transaction aborts immediately; no ready pulse is produced.
- Request capture: in IDLE with transfer=1, latch addr/wdata/wstrb/write into registers. AXI address, data and strobe outputs are driven only from these registers, never from the live inputs. transfer is ignored while busy=1.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE.
- IDLE:
  - transfer & write → WR_AW_W.
  - transfer & ~write → RD_AR.
- WR_AW_W:
  - AWVALID and WVALID are both registered high on entry.
  - Each drops the cycle after its own handshake (VALID&READY), tracked by aw_done and w_done flags.
  - The two handshakes may complete in either order or in the same cycle.
  - When both are done → WR_B. A VALID is never dropped before its handshake.
- WR_B: BREADY=1. On BVALID, capture BRESP into resp → DONE.
- RD_AR: ARVALID=1 until ARVALID&ARREADY → RD_R.
- RD_R: RREADY=1. On RVALID, capture RDATA into rdata and RRESP into resp → DONE.
- DONE: ready=1 for exactly one cycle → IDLE. A new transfer is accepted in the following cycle.
- Latency with slave readies and responses always asserted:
  - Write: transfer at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, ready at cycle 3.
  - Read: transfer at cycle 0, AR handshake at cycle 1, R handshake at cycle 2, ready at cycle 3.
- Timeout:
  - A counter resets on entry to WR_B/RD_R and increments each cycle spent there.
  - When it reaches TIMEOUT with no response: drop BREADY/RREADY, set resp=2'b10, timeout_err=1 → DONE.
  - rdata is not updated on a read timeout.
  - A response arriving in the same cycle the limit is reached wins over the timeout.
  - No timeout applies in AW/W/AR states, since AXI forbids withdrawing VALID.
- timeout_err: cleared on the next transfer acceptance.
- Slave response codes: SLVERR and DECERR pass through to resp unchanged; resp is not interpreted.

Test Plan:
- Write, all slave readies high: addr=0x4, wdata=0xDEADBEEF, wstrb=0xF → AWADDR=0x4, WDATA=0xDEADBEEF and WSTRB=0xF at cycle 1; ready at cycle 3; resp=00.
- AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID held 4 cycles, single BREADY phase, exactly one ready pulse.
- Read addr=0x8, slave RDATA=0x12345678 with RRESP=00 after 2-cycle RVALID delay → rdata=0x12345678 with ready; rdata still 0x12345678 after a subsequent write.
- TIMEOUT=8, BVALID never asserted → BREADY high for 8 cycles then low; ready=1, resp=10, timeout_err=1; next write completes normally with timeout_err=0.
- transfer held high through a whole read, with live addr changed mid-transaction → ARADDR stays at the latched value; next transaction starts only after the cycle following DONE.
- ARESETn=0 during WR_B → next cycle all VALID/READY=0, busy=0, no ready pulse; a subsequent read completes correctly.

Source files
------------

// File: rtl/axi_lite_master_param.sv
// ---------------------------------------------------------------------------
// axi_lite_master_param
//
// Purpose:
//   Bridges a simple single-request interface (transfer/write/addr/wdata/
//   wstrb -> ready/rdata/resp) to the five AXI4-Lite channels. One
//   transaction is in flight at a time. The response phase (B or R) is
//   guarded by a cycle counter so a silent slave cannot hang the requester.
//
// Parameters:
//   ADDR_W  - address width of AWADDR/ARADDR/addr
//   DATA_W  - data width, 32 or 64 (strobes are DATA_W/8 bits)
//   TIMEOUT - cycles allowed in WR_B/RD_R before aborting; 0 disables it
//
// Ports:
//   ACLK, ARESETn       - clock, synchronous active-low reset
//   AW*/W*/B*           - AXI-Lite write address, data and response channels
//   AR*/R*              - AXI-Lite read address and data channels
//   transfer, write     - request strobe (sampled only in IDLE) and direction
//   addr, wdata, wstrb  - request payload, latched on acceptance
//   busy                - high in every state except IDLE
//   ready               - one-cycle completion pulse
//   rdata               - last successfully read data
//   resp                - BRESP/RRESP of the last transaction, 2'b10 on timeout
//   timeout_err         - set when the last transaction was aborted by timeout
// ---------------------------------------------------------------------------
module axi_lite_master_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                ACLK,
  input  logic                ARESETn,

  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,

  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,

  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,

  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,

  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY,

  input  logic                transfer,
  input  logic                write,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,

  output logic                busy,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          resp,
  output logic                timeout_err
);

  localparam int STRB_W = DATA_W / 8;

  // The counter only ever has to reach TIMEOUT-1: the abort decision is made
  // in the cycle whose count equals TIMEOUT-1, i.e. the TIMEOUT-th cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic                timeout_err_q, timeout_err_d;

  logic                aw_hs;
  logic                w_hs;
  logic                tmo_hit;

  assign aw_hs   = awvalid_q & AWREADY;
  assign w_hs    = wvalid_q & WREADY;
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

  // Next-state and next-output logic. Every output is registered, so each
  // VALID/READY is set up on the transition into the state that owns it.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    cnt_d         = cnt_q;
    ready_d       = 1'b0;
    rdata_d       = rdata_q;
    resp_d        = resp_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          addr_d        = addr;
          wdata_d       = wdata;
          wstrb_d       = wstrb;
          timeout_err_d = 1'b0;
          if (write) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end

      // AW and W complete independently; each VALID falls only after its
      // own handshake, and the state advances once both have happened.
      WR_AW_W: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
        end
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
          cnt_d    = '0;
        end
      end

      // A response arriving in the limit cycle is checked first so it wins.
      WR_B: begin
        if (BVALID) begin
          resp_d   = BRESP;
          bready_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = DONE;
        end else if (tmo_hit) begin
          resp_d        = RESP_SLVERR;
          timeout_err_d = 1'b1;
          bready_d      = 1'b0;
          ready_d       = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RD_AR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
          state_d   = RD_R;
        end
      end

      // rdata is left untouched on a timeout abort.
      RD_R: begin
        if (RVALID) begin
          rdata_d  = RDATA;
          resp_d   = RRESP;
          rready_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = DONE;
        end else if (tmo_hit) begin
          resp_d        = RESP_SLVERR;
          timeout_err_d = 1'b1;
          rready_d      = 1'b0;
          ready_d       = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Single state register for the whole FSM; reset aborts any transaction
  // in progress without producing a ready pulse.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
      rdata_q       <= '0;
      resp_q        <= 2'b00;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
      resp_q        <= resp_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // AXI payloads come only from the latched request, never the live inputs.
  assign AWADDR      = addr_q;
  assign ARADDR      = addr_q;
  assign WDATA       = wdata_q;
  assign WSTRB       = wstrb_q;
  assign AWVALID     = awvalid_q;
  assign WVALID      = wvalid_q;
  assign BREADY      = bready_q;
  assign ARVALID     = arvalid_q;
  assign RREADY      = rready_q;
  assign busy        = busy_q;
  assign ready       = ready_q;
  assign rdata       = rdata_q;
  assign resp        = resp_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_axi_lite_master_param.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_master_param
//
// Directed bench for axi_lite_master_param (TIMEOUT = 8). A behavioural
// AXI-Lite slave with per-channel ready/response delays answers the DUT.
// Each issued request pushes its hand-computed completion (resp, rdata,
// timeout_err, latency) onto a queue; a monitor pops and compares on every
// ready pulse. Signal-level checks are made directly by the stimulus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_lite_master_param;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = DATA_W / 8;
  localparam int TIMEOUT = 8;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY = 1'b0;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WVALID;
  logic              WREADY = 1'b0;
  logic [1:0]        BRESP = 2'b00;
  logic              BVALID = 1'b0;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY = 1'b0;
  logic [DATA_W-1:0] RDATA = '0;
  logic [1:0]        RRESP = 2'b00;
  logic              RVALID = 1'b0;
  logic              RREADY;
  logic              transfer = 1'b0;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [STRB_W-1:0] wstrb = '0;
  logic              busy;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        resp;
  logic              timeout_err;

  axi_lite_master_param #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .AWADDR     (AWADDR),
    .AWVALID    (AWVALID),
    .AWREADY    (AWREADY),
    .WDATA      (WDATA),
    .WSTRB      (WSTRB),
    .WVALID     (WVALID),
    .WREADY     (WREADY),
    .BRESP      (BRESP),
    .BVALID     (BVALID),
    .BREADY     (BREADY),
    .ARADDR     (ARADDR),
    .ARVALID    (ARVALID),
    .ARREADY    (ARREADY),
    .RDATA      (RDATA),
    .RRESP      (RRESP),
    .RVALID     (RVALID),
    .RREADY     (RREADY),
    .transfer   (transfer),
    .write      (write),
    .addr       (addr),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .busy       (busy),
    .ready      (ready),
    .rdata      (rdata),
    .resp       (resp),
    .timeout_err(timeout_err)
  );

  always #5 ACLK = ~ACLK;

  int cycleCount = 0;
  always @(posedge ACLK) cycleCount <= cycleCount + 1;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
    int          lat;
    int          startCycle;
  } exp_t;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  // Slave behaviour knobs, changed by the stimulus between transactions.
  int          awDelay = 0;
  int          wDelay = 0;
  int          arDelay = 0;
  int          bDelay = 0;
  int          rDelay = 0;
  logic        bNever = 1'b0;
  logic [1:0]  slaveBresp = 2'b00;
  logic [1:0]  slaveRresp = 2'b00;
  logic [31:0] slaveRdata = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues a request in one cycle (cycle 0) and returns 1 ns after the edge
  // that starts cycle 1. Unless hold is set, transfer drops and the live
  // payload is scrambled so the DUT must be using its latched copy.
  task automatic applyStimulus(input logic isWrite, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               input logic [31:0] eRdata, input logic [1:0] eResp,
                               input logic eTmo, input int eLat, input logic hold);
    exp_t e;
    @(posedge ACLK); #1;
    transfer = 1'b1;
    write    = isWrite;
    addr     = a;
    wdata    = d;
    wstrb    = s;
    e.rdata      = eRdata;
    e.resp       = eResp;
    e.tmo        = eTmo;
    e.lat        = eLat;
    e.startCycle = cycleCount;
    expQ.push_back(e);
    @(posedge ACLK); #1;
    if (!hold) begin
      transfer = 1'b0;
      addr     = 32'hFFFF_FFFF;
      wdata    = 32'h0;
      wstrb    = 4'h0;
    end
  endtask

  task automatic waitReady(input int maxCycles);
    int n = 0;
    while (!ready && n < maxCycles) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("ready within cycle budget", 64'(ready), 64'd1);
    @(posedge ACLK);
  endtask

  // Behavioural slave: each READY/VALID rises once its channel has waited the
  // configured number of cycles, evaluated 1 ns after every rising edge.
  initial begin
    int awCnt = 0, wCnt = 0, arCnt = 0, bCnt = 0, rCnt = 0;
    forever begin
      @(posedge ACLK); #1;
      if (AWVALID) begin AWREADY = (awCnt >= awDelay); awCnt++; end
      else begin AWREADY = 1'b0; awCnt = 0; end
      if (WVALID) begin WREADY = (wCnt >= wDelay); wCnt++; end
      else begin WREADY = 1'b0; wCnt = 0; end
      if (ARVALID) begin ARREADY = (arCnt >= arDelay); arCnt++; end
      else begin ARREADY = 1'b0; arCnt = 0; end
      if (BREADY && !bNever) begin BVALID = (bCnt >= bDelay); bCnt++; end
      else begin BVALID = 1'b0; bCnt = 0; end
      if (RREADY) begin RVALID = (rCnt >= rDelay); rCnt++; end
      else begin RVALID = 1'b0; rCnt = 0; end
      BRESP = slaveBresp;
      RRESP = slaveRresp;
      RDATA = slaveRdata;
    end
  end

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (ready) begin
        if (expQ.size() == 0) begin
          checkOutput("scoreboard entry at ready", 64'(expQ.size()), 64'd1);
        end else begin
          e = expQ.pop_front();
          checkOutput("resp", 64'(resp), 64'(e.resp));
          checkOutput("timeout_err", 64'(timeout_err), 64'(e.tmo));
          checkOutput("rdata", 64'(rdata), 64'(e.rdata));
          checkOutput("latency", 64'(cycleCount - e.startCycle), 64'(e.lat));
          checkOutput("busy with ready", 64'(busy), 64'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int awHigh, wHigh, bHigh, readyCnt;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("reset control outputs",
                64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, ready, busy, timeout_err}), 64'd0);
    checkOutput("reset rdata", 64'(rdata), 64'd0);
    checkOutput("reset resp", 64'(resp), 64'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // Write, all readies immediate: ready at cycle 3
    applyStimulus(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 1'b0, 3, 1'b0);
    @(negedge ACLK);
    checkOutput("AWADDR cycle 1", 64'(AWADDR), 64'h4);
    checkOutput("WDATA cycle 1", 64'(WDATA), 64'hDEAD_BEEF);
    checkOutput("WSTRB cycle 1", 64'(WSTRB), 64'hF);
    checkOutput("AWVALID/WVALID cycle 1", 64'({AWVALID, WVALID}), 64'b11);
    checkOutput("busy cycle 1", 64'(busy), 64'd1);
    waitReady(20);

    // AWREADY delayed 3 cycles, slave answers SLVERR
    awDelay = 3; slaveBresp = 2'b10;
    awHigh = 0; wHigh = 0; bHigh = 0; readyCnt = 0;
    applyStimulus(1'b1, 32'h10, 32'hCAFE_F00D, 4'h3, 32'h0, 2'b10, 1'b0, 6, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge ACLK);
      if (k == 1) checkOutput("WDATA latched", 64'(WDATA), 64'hCAFE_F00D);
      awHigh += int'(AWVALID);
      wHigh += int'(WVALID);
      bHigh += int'(BREADY);
      readyCnt += int'(ready);
    end
    checkOutput("AWVALID cycles", 64'(awHigh), 64'd4);
    checkOutput("WVALID cycles", 64'(wHigh), 64'd1);
    checkOutput("BREADY cycles", 64'(bHigh), 64'd1);
    checkOutput("ready pulses", 64'(readyCnt), 64'd1);
    awDelay = 0; slaveBresp = 2'b00;

    // Read with RVALID delayed 2 cycles
    rDelay = 2; slaveRdata = 32'h1234_5678; slaveRresp = 2'b00;
    applyStimulus(1'b0, 32'h8, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 1'b0, 5, 1'b0);
    @(negedge ACLK);
    checkOutput("ARADDR cycle 1", 64'(ARADDR), 64'h8);
    waitReady(20);
    rDelay = 0;

    // Write afterwards leaves rdata intact
    applyStimulus(1'b1, 32'hC, 32'h1111_1111, 4'hF, 32'h1234_5678, 2'b00, 1'b0, 3, 1'b0);
    waitReady(20);

    // No B response: BREADY high for TIMEOUT cycles then abort
    bNever = 1'b1;
    bHigh = 0; readyCnt = 0;
    applyStimulus(1'b1, 32'h20, 32'h2222_2222, 4'hF, 32'h1234_5678, 2'b10, 1'b1, 10, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge ACLK);
      bHigh += int'(BREADY);
      readyCnt += int'(ready);
    end
    checkOutput("BREADY cycles before timeout", 64'(bHigh), 64'd8);
    checkOutput("timeout ready pulses", 64'(readyCnt), 64'd1);
    bNever = 1'b0;

    // Next write completes normally and clears timeout_err
    applyStimulus(1'b1, 32'h24, 32'h3333_3333, 4'hF, 32'h1234_5678, 2'b00, 1'b0, 3, 1'b0);
    waitReady(20);

    // B response in the very cycle the limit is reached wins
    bDelay = 7; slaveBresp = 2'b01;
    applyStimulus(1'b1, 32'h28, 32'h4444_4444, 4'hF, 32'h1234_5678, 2'b01, 1'b0, 10, 1'b0);
    waitReady(20);
    bDelay = 0; slaveBresp = 2'b00;

    // transfer held high through a read, live addr changed mid-flight;
    // a second read is accepted in the IDLE cycle after DONE
    slaveRdata = 32'hA5A5_0000; slaveRresp = 2'b11;
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 32'hA5A5_0000, 2'b11, 1'b0, 3, 1'b1);
    addr = 32'h99;
    @(negedge ACLK);
    checkOutput("ARADDR latched", 64'(ARADDR), 64'h30);
    @(negedge ACLK);
    @(negedge ACLK);
    @(negedge ACLK);
    checkOutput("IDLE gap after DONE", 64'({busy, ARVALID}), 64'd0);
    begin
      exp_t e2;
      e2.rdata = 32'hA5A5_0000; e2.resp = 2'b11; e2.tmo = 1'b0;
      e2.lat = 3; e2.startCycle = cycleCount;
      expQ.push_back(e2);
    end
    @(posedge ACLK); #1;
    transfer = 1'b0;
    @(negedge ACLK);
    checkOutput("second read ARVALID", 64'(ARVALID), 64'd1);
    checkOutput("second read ARADDR", 64'(ARADDR), 64'h99);
    waitReady(20);
    slaveRresp = 2'b00;

    // Reset during WR_B aborts without a ready pulse
    bDelay = 5;
    @(posedge ACLK); #1;
    transfer = 1'b1; write = 1'b1; addr = 32'h50; wdata = 32'h5555_5555; wstrb = 4'hF;
    @(posedge ACLK); #1;
    transfer = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    checkOutput("BREADY in WR_B", 64'(BREADY), 64'd1);
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    readyCnt = 0;
    @(negedge ACLK);
    checkOutput("after reset control outputs",
                64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, ready, busy, timeout_err}), 64'd0);
    checkOutput("after reset rdata", 64'(rdata), 64'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK);
      readyCnt += int'(ready);
    end
    checkOutput("no ready after reset", 64'(readyCnt), 64'd0);
    bDelay = 0;

    // Read after reset
    slaveRdata = 32'h0BAD_F00D;
    applyStimulus(1'b0, 32'h40, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 1'b0, 3, 1'b0);
    waitReady(20);

    repeat (4) @(negedge ACLK);
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
